// File: rtl/key_entry_ctrl.sv
// Passcode entry controller: owns the 6-digit display buffer, compares against
// PASSCODE on enter, and sequences timed PASS/FAIL holds and lockout.
module key_entry_ctrl #(
  parameter logic [23:0] PASSCODE    = 24'h123456,
  parameter int          MAX_FAIL    = 3,
  parameter int          HOLD_CYCLES = 16,
  parameter int          LOCK_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [23:0] display_code,
  output logic [2:0]  digit_cnt,
  output logic        unlock,
  output logic        fail_flag,
  output logic        alarm,
  output logic [2:0]  fail_cnt,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    ENTRY  = 3'd0,
    CHECK  = 3'd1,
    PASS   = 3'd2,
    FAIL   = 3'd3,
    LOCKED = 3'd4
  } state_t;

  localparam logic [23:0] BLANK     = 24'hFFFFFF;
  localparam logic [15:0] HOLD_INIT = 16'(HOLD_CYCLES);
  localparam logic [15:0] LOCK_INIT = 16'(LOCK_CYCLES);
  localparam logic [3:0]  FAIL_LIM  = 4'(MAX_FAIL);

  state_t      state_q, state_d;
  logic [23:0] disp_q, disp_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  fail_q, fail_d;
  logic [15:0] timer_q, timer_d;
  logic        unlock_q, unlock_d;
  logic        fail_flag_q, fail_flag_d;
  logic        alarm_q, alarm_d;
  logic        match;
  logic [3:0]  fail_next;

  assign match     = (cnt_q == 3'd6) && (disp_q == PASSCODE);
  assign fail_next = {1'b0, fail_q} + 4'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ENTRY;
      disp_q      <= BLANK;
      cnt_q       <= 3'd0;
      fail_q      <= 3'd0;
      timer_q     <= 16'd0;
      unlock_q    <= 1'b0;
      fail_flag_q <= 1'b0;
      alarm_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      disp_q      <= disp_d;
      cnt_q       <= cnt_d;
      fail_q      <= fail_d;
      timer_q     <= timer_d;
      unlock_q    <= unlock_d;
      fail_flag_q <= fail_flag_d;
      alarm_q     <= alarm_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    disp_d      = disp_q;
    cnt_d       = cnt_q;
    fail_d      = fail_q;
    timer_d     = timer_q;
    unlock_d    = unlock_q;
    fail_flag_d = fail_flag_q;
    alarm_d     = alarm_q;

    case (state_q)
      ENTRY: begin
        if (key_valid) begin
          if (key_code <= 4'd9) begin
            if (cnt_q < 3'd6) begin
              disp_d = {disp_q[19:0], key_code};
              cnt_d  = cnt_q + 3'd1;
            end
          end else if (key_code == 4'hA) begin
            disp_d = BLANK;
            cnt_d  = 3'd0;
          end else if (key_code == 4'hB) begin
            state_d = CHECK;
          end else if (key_code == 4'hC) begin
            if (cnt_q != 3'd0) begin
              disp_d = {4'hF, disp_q[23:4]};
              cnt_d  = cnt_q - 3'd1;
            end
          end
        end
      end

      CHECK: begin
        if (match) begin
          state_d  = PASS;
          fail_d   = 3'd0;
          timer_d  = HOLD_INIT;
          unlock_d = 1'b1;
        end else if (fail_next < FAIL_LIM) begin
          state_d     = FAIL;
          fail_d      = fail_next[2:0];
          timer_d     = HOLD_INIT;
          fail_flag_d = 1'b1;
        end else begin
          // Lockout blanks the buffer up front so no partial code stays visible.
          state_d = LOCKED;
          fail_d  = FAIL_LIM[2:0];
          timer_d = LOCK_INIT;
          alarm_d = 1'b1;
          disp_d  = BLANK;
          cnt_d   = 3'd0;
        end
      end

      PASS, FAIL: begin
        if (timer_q <= 16'd1) begin
          state_d     = ENTRY;
          disp_d      = BLANK;
          cnt_d       = 3'd0;
          timer_d     = 16'd0;
          unlock_d    = 1'b0;
          fail_flag_d = 1'b0;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end

      LOCKED: begin
        if (timer_q <= 16'd1) begin
          state_d = ENTRY;
          fail_d  = 3'd0;
          timer_d = 16'd0;
          alarm_d = 1'b0;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end

      default: begin
        state_d     = ENTRY;
        disp_d      = BLANK;
        cnt_d       = 3'd0;
        timer_d     = 16'd0;
        unlock_d    = 1'b0;
        fail_flag_d = 1'b0;
        alarm_d     = 1'b0;
      end
    endcase
  end

  assign display_code = disp_q;
  assign digit_cnt    = cnt_q;
  assign unlock       = unlock_q;
  assign fail_flag    = fail_flag_q;
  assign alarm        = alarm_q;
  assign fail_cnt     = fail_q;
  assign state        = state_q;

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Directed bench for key_entry_ctrl: expected buffer/state snapshots are queued
// when a step is driven and compared when the DUT result is sampled.
module tb_key_entry_ctrl;

  logic        clk;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [23:0] display_code;
  logic [2:0]  digit_cnt;
  logic        unlock;
  logic        fail_flag;
  logic        alarm;
  logic [2:0]  fail_cnt;
  logic [2:0]  state;

  int checks;
  int failures;

  typedef struct {
    string       tag;
    logic [23:0] disp;
    logic [2:0]  cnt;
    logic [2:0]  fcnt;
    logic [2:0]  st;
  } exp_t;

  exp_t sb[$];

  key_entry_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .display_code (display_code),
    .digit_cnt    (digit_cnt),
    .unlock       (unlock),
    .fail_flag    (fail_flag),
    .alarm        (alarm),
    .fail_cnt     (fail_cnt),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_top(input string tag, input logic [23:0] disp, input logic [2:0] cnt,
                            input logic [2:0] fcnt, input logic [2:0] st);
    exp_t e;
    e.tag = tag; e.disp = disp; e.cnt = cnt; e.fcnt = fcnt; e.st = st;
    sb.push_back(e);
  endtask

  task automatic check_top();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".disp"}, 32'(display_code), 32'(e.disp));
      chk({e.tag, ".cnt"},  32'(digit_cnt),    32'(e.cnt));
      chk({e.tag, ".fcnt"}, 32'(fail_cnt),     32'(e.fcnt));
      chk({e.tag, ".st"},   32'(state),        32'(e.st));
    end
  endtask

  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  task automatic key_step(input logic [3:0] k, input string tag, input logic [23:0] disp,
                          input logic [2:0] cnt, input logic [2:0] fcnt, input logic [2:0] st);
    expect_top(tag, disp, cnt, fcnt, st);
    press(k);
    check_top();
  endtask

  function automatic logic pick(input int sel);
    case (sel)
      0:       return unlock;
      1:       return fail_flag;
      default: return alarm;
    endcase
  endfunction

  // Counts consecutive sampled cycles the selected flag stays high.
  task automatic measure(input int sel, input int start, input int exp_len, input string tag);
    int n = start;
    logic excl_bad = 1'b0;
    while (pick(sel) === 1'b1 && n < 1000) begin
      if (int'(unlock) + int'(fail_flag) + int'(alarm) > 1) excl_bad = 1'b1;
      n++;
      @(negedge clk);
    end
    chk({tag, ".len"}, 32'(n), 32'(exp_len));
    chk({tag, ".excl"}, 32'(excl_bad), 32'd0);
  endtask

  task automatic enter_and_check(input string tag, input logic [2:0] exp_st, input logic [2:0] exp_fcnt);
    press(4'hB);
    chk({tag, ".check_st"}, 32'(state), 32'd1);
    chk({tag, ".check_flags"}, 32'({unlock, fail_flag, alarm}), 32'd0);
    @(negedge clk);
    chk({tag, ".st"}, 32'(state), 32'(exp_st));
    chk({tag, ".fcnt"}, 32'(fail_cnt), 32'(exp_fcnt));
  endtask

  task automatic enter_digits(input logic [23:0] code);
    logic [23:0] c;
    c = code;
    for (int i = 0; i < 6; i++) begin
      press(c[23:20]);
      c = c << 4;
    end
  endtask

  task automatic wrong_fail(input string tag, input logic [2:0] fcnt_before, input logic [2:0] fcnt_after);
    enter_digits(24'h999999);
    expect_top({tag, ".pre"}, 24'h999999, 3'd6, fcnt_before, 3'd0);
    check_top();
    enter_and_check(tag, 3'd3, fcnt_after);
    chk({tag, ".flag"}, 32'(fail_flag), 32'd1);
    measure(1, 0, 16, {tag, ".hold"});
    expect_top({tag, ".exit"}, 24'hFFFFFF, 3'd0, fcnt_after, 3'd0);
    check_top();
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    key_valid = 1'b0;
    key_code  = 4'h0;
    rst       = 1'b0;

    // Reset values while held in reset.
    #12;
    expect_top("rst", 24'hFFFFFF, 3'd0, 3'd0, 3'd0);
    check_top();
    chk("rst.flags", 32'({unlock, fail_flag, alarm}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Correct passcode.
    key_step(4'd1, "p1", 24'hFFFFF1, 3'd1, 3'd0, 3'd0);
    key_step(4'd2, "p2", 24'hFFFF12, 3'd2, 3'd0, 3'd0);
    key_step(4'd3, "p3", 24'hFFF123, 3'd3, 3'd0, 3'd0);
    key_step(4'd4, "p4", 24'hFF1234, 3'd4, 3'd0, 3'd0);
    key_step(4'd5, "p5", 24'hF12345, 3'd5, 3'd0, 3'd0);
    key_step(4'd6, "p6", 24'h123456, 3'd6, 3'd0, 3'd0);
    enter_and_check("pass", 3'd2, 3'd0);
    chk("pass.unlock", 32'(unlock), 32'd1);
    measure(0, 0, 16, "pass.hold");
    expect_top("pass.exit", 24'hFFFFFF, 3'd0, 3'd0, 3'd0);
    check_top();

    // Editing: overflow digit, backspace, clear, backspace on empty, undefined code.
    enter_digits(24'h123456);
    key_step(4'd7, "ovf",   24'h123456, 3'd6, 3'd0, 3'd0);
    key_step(4'hC, "bs",    24'hF12345, 3'd5, 3'd0, 3'd0);
    key_step(4'hE, "undef", 24'hF12345, 3'd5, 3'd0, 3'd0);
    key_step(4'hA, "clr",   24'hFFFFFF, 3'd0, 3'd0, 3'd0);
    key_step(4'hC, "bs0",   24'hFFFFFF, 3'd0, 3'd0, 3'd0);

    // Short entry never matches; keys during FAIL are ignored.
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5);
    enter_and_check("short", 3'd3, 3'd1);
    key_step(4'd7, "short.key", 24'hF12345, 3'd5, 3'd1, 3'd3);
    measure(1, 1, 16, "short.hold");
    expect_top("short.exit", 24'hFFFFFF, 3'd0, 3'd1, 3'd0);
    check_top();

    // Second failure, then a correct code clears the count.
    wrong_fail("w2", 3'd1, 3'd2);
    enter_digits(24'h123456);
    enter_and_check("pass2", 3'd2, 3'd0);
    measure(0, 0, 16, "pass2.hold");
    wrong_fail("w_after_pass", 3'd0, 3'd1);

    // Reset mid-entry with three digits.
    press(4'd1); press(4'd2); press(4'd3);
    #2 rst = 1'b0;
    #1;
    expect_top("rst_entry", 24'hFFFFFF, 3'd0, 3'd0, 3'd0);
    check_top();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    key_step(4'd5, "after_rst", 24'hFFFFF5, 3'd1, 3'd0, 3'd0);
    press(4'hA);

    // Three wrong entries lead to lockout.
    wrong_fail("l1", 3'd0, 3'd1);
    wrong_fail("l2", 3'd1, 3'd2);
    enter_digits(24'h999999);
    enter_and_check("l3", 3'd4, 3'd3);
    chk("l3.alarm", 32'(alarm), 32'd1);
    key_step(4'd4, "l3.key", 24'hFFFFFF, 3'd0, 3'd3, 3'd4);
    measure(2, 1, 64, "l3.lock");
    expect_top("l3.exit", 24'hFFFFFF, 3'd0, 3'd0, 3'd0);
    check_top();

    // Second lockout, then reset roughly halfway through.
    wrong_fail("m1", 3'd0, 3'd1);
    wrong_fail("m2", 3'd1, 3'd2);
    enter_digits(24'h999999);
    enter_and_check("m3", 3'd4, 3'd3);
    repeat (34) @(negedge clk);
    chk("m3.alarm_mid", 32'(alarm), 32'd1);
    #2 rst = 1'b0;
    #1;
    expect_top("rst_lock", 24'hFFFFFF, 3'd0, 3'd0, 3'd0);
    check_top();
    chk("rst_lock.flags", 32'({unlock, fail_flag, alarm}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    key_step(4'd5, "after_rst2", 24'hFFFFF5, 3'd1, 3'd0, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_entry_ctrl.md
Name: key_entry_ctrl

Overview:
- Sequencing controller for the 6-digit keypad/display path.
- Consumes one-cycle debounced key events (the debounce press_valid pulse plus the 4-bit scan code) and owns the 24-bit display_code buffer feeding the digit mux.
- Runs passcode entry: digit shift-in, clear, backspace, enter/compare, pass hold, fail counting and timed lockout.
- Sits between the debounce stage and the display mux, replacing the plain shift buffer.

Parameters:
- PASSCODE, 24'h123456, six BCD nibbles; leftmost digit in [23:20].
- MAX_FAIL, 3, consecutive failed attempts that trigger lockout (1..7).
- HOLD_CYCLES, 16, clk cycles spent in PASS and in FAIL (1..65535).
- LOCK_CYCLES, 64, clk cycles spent in LOCKED (1..65535).

Ports:
- clk, input, 1, scan-rate clock (divided clock domain).
- rst, input, 1, asynchronous active-low reset.
- key_valid, input, 1, one-cycle key event strobe.
- key_code, input, 4, key value: 0-9 digit, 4'hA clear, 4'hB enter, 4'hC backspace; other values ignored.
- display_code, output, 24, six nibbles to the digit mux; 4'hF = blank.
- digit_cnt, output, 3, number of digits entered (0..6).
- unlock, output, 1, high while in PASS.
- fail_flag, output, 1, high while in FAIL.
- alarm, output, 1, high while in LOCKED.
- fail_cnt, output, 3, consecutive failures so far.
- state, output, 3, encoding: ENTRY=0, CHECK=1, PASS=2, FAIL=3, LOCKED=4.

Behaviour:
- Reset (rst low, async): state=ENTRY, display_code=24'hFFFFFF, digit_cnt=0, fail_cnt=0, unlock=0, fail_flag=0, alarm=0, timer=0. All outputs are registered.
- ENTRY:
  - Digit with digit_cnt<6: display_code <= {display_code[19:0], key}, digit_cnt+1. Visible the cycle after the strobe edge.
  - Digit with digit_cnt=6: ignored; buffer unchanged.
  - Clear (A): display_code=24'hFFFFFF, digit_cnt=0.
  - Backspace (C) with digit_cnt>0: display_code <= {4'hF, display_code[23:4]}, digit_cnt-1. With digit_cnt=0: no-op.
  - Enter (B): go to CHECK regardless of digit_cnt.
  - Undefined codes and key_valid=0: no change.
- CHECK (exactly 1 cycle): match = (digit_cnt==6) && (display_code==PASSCODE).
  - match: go to PASS, fail_cnt=0.
  - no match, fail_cnt+1 < MAX_FAIL: go to FAIL, fail_cnt+1.
  - no match, fail_cnt+1 = MAX_FAIL: go to LOCKED, fail_cnt=MAX_FAIL.
  - In every case timer is loaded with the matching HOLD_CYCLES or LOCK_CYCLES. Latency: enter strobe at edge N, unlock/fail_flag/alarm high after edge N+1.
- PASS / FAIL:
  - Flag high for exactly HOLD_CYCLES cycles; timer decrements each cycle.
  - At timer expiry: state=ENTRY, display_code=24'hFFFFFF, digit_cnt=0, flag low.
  - fail_cnt is unchanged on exit from FAIL.
- LOCKED:
  - alarm high for exactly LOCK_CYCLES cycles; display_code forced to 24'hFFFFFF on entry.
  - At expiry: state=ENTRY, fail_cnt=0, alarm low.
- key_valid is ignored in CHECK, PASS, FAIL and LOCKED; nothing is queued.
- At most one of unlock, fail_flag, alarm is high at any time.
- Reset asserted mid-operation (any state, any timer value): immediate return to reset values; no partial state survives.
- Timer is 16-bit and does not wrap below zero: expiry is detected at timer==1, and the state changes on that edge.

Test Plan:
- Reset, then keys 1,2,3,4,5,6 then B -> display_code=24'h123456 before enter; unlock high exactly 16 cycles starting 2 edges after the B strobe; then display_code=24'hFFFFFF, digit_cnt=0, fail_cnt=0.
- Keys 1..7 (7 digits) -> 7th ignored, display_code=24'h123456, digit_cnt=6. Then C -> 24'hF12345, digit_cnt=5. Then A -> 24'hFFFFFF, digit_cnt=0. C at digit_cnt=0 -> no change.
- Enter with 5 digits 12345 -> FAIL (short entry never matches): fail_flag 16 cycles, fail_cnt=1; keys pressed during FAIL have no effect on display_code.
- Three wrong entries (999999+B, three times) -> first two go to FAIL with fail_cnt 1 then 2; third goes to LOCKED, alarm high 64 cycles, keys ignored; after lockout fail_cnt=0 and state=ENTRY.
- Two failures, then correct 123456+B -> PASS and fail_cnt clears to 0; a subsequent wrong entry gives fail_cnt=1, not 3.
- rst pulsed low mid-LOCKED with timer ≈30 and again mid-entry with 3 digits -> asynchronous return to all reset values; the next key 5 gives display_code=24'hFFFFF5.
